// File: rtl/pulse_train_sequencer_if.sv
// Control/status bundle of the pulse train sequencer: trigger, timebase, train config and pulse status.
interface pulse_train_sequencer_if #(
   parameter int unsigned TW = 8,
   parameter int unsigned CW = 8
);
   logic          ce;
   logic          start;
   logic          abort;
   logic [TW-1:0] width;
   logic [TW-1:0] gap;
   logic [CW-1:0] count;
   logic          y;
   logic          busy;
   logic          done;
   logic [CW-1:0] pulse_idx;

   modport master (
      output ce, start, abort, width, gap, count,
      input  y, busy, done, pulse_idx
   );

   modport slave (
      input  ce, start, abort, width, gap, count,
      output y, busy, done, pulse_idx
   );
endinterface

// File: rtl/pulse_train_sequencer.sv
// Generates a burst of count pulses (width ce-ticks high, gap ce-ticks low) on a rising start edge,
// timing both the high and low phases with one shared phase counter.
module pulse_train_sequencer #(
   parameter int unsigned TW = 8,
   parameter int unsigned CW = 8
) (
   input logic                    clk,
   input logic                    rst,
   pulse_train_sequencer_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PULSE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state, state_n;
   logic [TW-1:0] phase, phase_n;
   logic [TW-1:0] wid_q, wid_n;
   logic [TW-1:0] gap_q, gap_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic [CW-1:0] idx_q, idx_n;
   logic          startd;
   logic          y_q, busy_q, done_q;
   logic          start_edge_c;
   logic [TW-1:0] gap_last_c;

   // A zero gap is stretched to one tick so consecutive pulses never merge.
   always_comb begin
      start_edge_c = bus.start & ~startd;
      gap_last_c   = (gap_q == '0) ? '0 : gap_q - TW'(1);
   end

   always_comb begin
      state_n = state;
      phase_n = phase;
      wid_n   = wid_q;
      gap_n   = gap_q;
      cnt_n   = cnt_q;
      idx_n   = idx_q;
      case (state)
         S_IDLE, S_DONE: begin
            if (start_edge_c) begin
               wid_n   = bus.width;
               gap_n   = bus.gap;
               cnt_n   = bus.count;
               phase_n = '0;
               idx_n   = '0;
               state_n = ((bus.width == '0) || (bus.count == '0)) ? S_DONE : S_PULSE;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_PULSE: begin
            if (bus.abort) begin
               state_n = S_IDLE;
            end else if (bus.ce) begin
               if (phase == wid_q - TW'(1)) begin
                  phase_n = '0;
                  state_n = (idx_q == cnt_q - CW'(1)) ? S_DONE : S_GAP;
               end else begin
                  phase_n = phase + TW'(1);
               end
            end
         end
         default: begin
            if (bus.abort) begin
               state_n = S_IDLE;
            end else if (bus.ce) begin
               if (phase == gap_last_c) begin
                  phase_n = '0;
                  idx_n   = idx_q + CW'(1);
                  state_n = S_PULSE;
               end else begin
                  phase_n = phase + TW'(1);
               end
            end
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         phase  <= '0;
         wid_q  <= '0;
         gap_q  <= '0;
         cnt_q  <= '0;
         idx_q  <= '0;
         startd <= 1'b0;
         y_q    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         phase  <= phase_n;
         wid_q  <= wid_n;
         gap_q  <= gap_n;
         cnt_q  <= cnt_n;
         idx_q  <= idx_n;
         startd <= bus.start;
         y_q    <= (state_n == S_PULSE);
         busy_q <= (state_n == S_PULSE) || (state_n == S_GAP);
         done_q <= (state_n == S_DONE);
      end
   end

   assign bus.y         = y_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pulse_idx = idx_q;

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Self-checking bench: a tick-count model of the pulse train is compared every cycle,
// with directed scenarios pinned by literal expectations plus a randomized soak.
module tb_pulse_train_sequencer;
   localparam int unsigned TW = 8;
   localparam int unsigned CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   pulse_train_sequencer_if #(.TW(TW), .CW(CW)) bus ();
   pulse_train_sequencer #(.TW(TW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: a train is a run of L = count*period - gap ce-ticks after the accepting edge.
   bit m_active, m_done, m_startd;
   int m_t, m_L, m_per, m_w, m_idx;
   int n_done, n_yrise, n_yhigh;
   bit prev_y;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_done = 1'b0; m_startd = 1'b0;
      m_t = 0; m_L = 0; m_per = 1; m_w = 0; m_idx = 0;
      prev_y = 1'b0;
   endtask

   task automatic model_edge();
      bit edge_s;
      int g;
      edge_s   = bus.start && !m_startd;
      m_startd = bus.start;
      m_done   = 1'b0;
      if (m_active) begin
         if (bus.abort) begin
            m_active = 1'b0;
         end else if (bus.ce) begin
            m_t++;
            if (m_t == m_L) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end else begin
               m_idx = m_t / m_per;
            end
         end
      end else if (edge_s) begin
         m_w   = int'(bus.width);
         g     = (bus.gap == '0) ? 1 : int'(bus.gap);
         m_per = m_w + g;
         m_idx = 0;
         m_t   = 0;
         if (bus.width == '0 || bus.count == '0) begin
            m_done = 1'b1;
         end else begin
            m_active = 1'b1;
            m_L      = int'(bus.count) * m_per - g;
         end
      end
   endtask

   task automatic compare();
      bit ey;
      ey = m_active && ((m_t % m_per) < m_w);
      checks++;
      if (bus.y !== ey || bus.busy !== m_active || bus.done !== m_done || int'(bus.pulse_idx) != m_idx) begin
         failures++;
         $display("FAIL cycle t=%0t y/busy/done/idx actual=%b/%b/%b/%0d required=%b/%b/%b/%0d",
                  $time, bus.y, bus.busy, bus.done, bus.pulse_idx, ey, m_active, m_done, m_idx);
      end
      if (bus.done) n_done++;
      if (bus.y && !prev_y) n_yrise++;
      if (bus.y) n_yhigh++;
      prev_y = bus.y;
   endtask

   task automatic step(input bit ce_v, input bit start_v, input bit abort_v);
      bus.ce = ce_v; bus.start = start_v; bus.abort = abort_v;
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      compare();
   endtask

   // Called with clk low; outputs must clear as soon as rst rises.
   task automatic do_reset(input string name);
      rst = 1'b1;
      #1;
      check({name, "_y"}, longint'(bus.y), 0);
      check({name, "_busy"}, longint'(bus.busy), 0);
      check({name, "_done"}, longint'(bus.done), 0);
      check({name, "_idx"}, longint'(bus.pulse_idx), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [8:0] yh, dh, bh;
      bus.ce = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
      bus.width = '0; bus.gap = '0; bus.count = '0;
      model_reset();
      #2;
      do_reset("reset");

      // Scenario 1: continuous ce, width=3 gap=2 count=2
      bus.width = 8'd3; bus.gap = 8'd2; bus.count = 8'd2;
      for (int i = 0; i < 9; i++) begin
         step(1'b1, i == 0, 1'b0);
         yh[i] = bus.y; dh[i] = bus.done; bh[i] = bus.busy;
      end
      check("t1_y", longint'(yh), longint'(9'b011100111));
      check("t1_done", longint'(dh), longint'(9'b100000000));
      check("t1_busy", longint'(bh), longint'(9'b011111111));
      step(1'b1, 1'b0, 1'b0);

      // Scenario 2: sparse ce, width=2 gap=1 count=1
      bus.width = 8'd2; bus.gap = 8'd1; bus.count = 8'd1;
      n_done = 0; n_yhigh = 0;
      for (int i = 0; i < 16; i++) step(i % 4 == 3, i == 0, 1'b0);
      check("t2_idx", longint'(bus.pulse_idx), 0);
      check("t2_ndone", n_done, 1);
      check("t2_yhigh", n_yhigh, 7);

      // Scenario 3: zero width, then zero count
      bus.width = 8'd0; bus.gap = 8'd2; bus.count = 8'd3;
      step(1'b1, 1'b1, 1'b0);
      check("t3a_done", longint'(bus.done), 1);
      check("t3a_busy", longint'(bus.busy), 0);
      step(1'b1, 1'b0, 1'b0);
      check("t3a_done_after", longint'(bus.done), 0);
      bus.width = 8'd3; bus.count = 8'd0;
      step(1'b1, 1'b1, 1'b0);
      check("t3b_done", longint'(bus.done), 1);
      check("t3b_y", longint'(bus.y), 0);
      step(1'b1, 1'b0, 1'b0);

      // Scenario 4: start held high with a second edge in the 2nd gap
      bus.width = 8'd4; bus.gap = 8'd4; bus.count = 8'd5;
      n_done = 0; n_yrise = 0;
      for (int i = 0; i < 46; i++) step(1'b1, (i <= 12) || (i >= 14 && i <= 33), 1'b0);
      check("t4_pulses", n_yrise, 5);
      check("t4_ndone", n_done, 1);

      // Scenario 5: abort during the 3rd pulse
      bus.width = 8'd3; bus.gap = 8'd2; bus.count = 8'd5;
      for (int i = 0; i < 12; i++) step(1'b1, i == 0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("t5_y", longint'(bus.y), 0);
      check("t5_busy", longint'(bus.busy), 0);
      check("t5_idx", longint'(bus.pulse_idx), 2);
      n_done = 0;
      repeat (20) step(1'b1, 1'b0, 1'b0);
      check("t5_ndone", n_done, 0);

      // Scenario 6: reset mid-gap, then a fresh train
      bus.width = 8'd3; bus.gap = 8'd3; bus.count = 8'd3;
      for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b0);
      check("t6_busy_pre", longint'(bus.busy), 1);
      do_reset("t6_rst");
      n_done = 0; n_yrise = 0;
      for (int i = 0; i < 20; i++) step(1'b1, i == 0, 1'b0);
      check("t6_pulses", n_yrise, 3);
      check("t6_ndone", n_done, 1);

      // Boundary: maximum width, zero gap stretched to one tick
      bus.width = 8'd255; bus.gap = 8'd0; bus.count = 8'd2;
      n_done = 0; n_yrise = 0; n_yhigh = 0;
      for (int i = 0; i < 520; i++) step(1'b1, i == 0, 1'b0);
      check("max_pulses", n_yrise, 2);
      check("max_yhigh", n_yhigh, 510);
      check("max_ndone", n_done, 1);

      // Randomized soak with config changing under a running train
      for (int i = 0; i < 3000; i++) begin
         bit st;
         if ($urandom_range(0, 3) == 0) begin
            bus.width = TW'($urandom_range(0, 5));
            bus.gap   = TW'($urandom_range(0, 3));
            bus.count = CW'($urandom_range(0, 4));
         end
         st = ($urandom_range(0, 7) == 0) ? !bus.start : bus.start;
         step($urandom_range(0, 3) != 0, st, $urandom_range(0, 63) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
